mem_stage: RTL and testbench

- Memory-access stage directly downstream of EX; consumes EX's aluop_o, mem_addr_o, w_data_o (store data / ALU result), is_ld and the write-back triple through the EX/MEM latch.
- Issues word-wide load/store requests to the memory controller over a req/ack handshake, holding the pipeline via stall_req_o while the access is outstanding.
- Aligns and extends load data (LB/LH/LW/LBU/LHU), builds byte masks for SB/SH/SW, and forwards the result to the MEM/WB latch.
- Non-memory ops pass through with zero latency.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_align.sv | 70 +++++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared pipeline types and opcodes for the memory stage:
//               ALU operation codes, bus types and the MEM FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int ALUOP_WIDTH = 8;
    localparam int REG_WIDTH   = 32;

    typedef logic [ALUOP_WIDTH-1:0] alu_op_bus_t;
    typedef logic [REG_WIDTH-1:0]   reg_bus_t;
    typedef logic [4:0]             reg_addr_bus_t;

    localparam reg_bus_t ZERO_WORD = '0;

    // EX-stage operation codes seen by the memory stage
    localparam alu_op_bus_t EX_NOP = 8'h00;
    localparam alu_op_bus_t EX_ADD = 8'h01;
    localparam alu_op_bus_t EX_LB  = 8'h10;
    localparam alu_op_bus_t EX_LH  = 8'h11;
    localparam alu_op_bus_t EX_LW  = 8'h12;
    localparam alu_op_bus_t EX_LBU = 8'h13;
    localparam alu_op_bus_t EX_LHU = 8'h14;
    localparam alu_op_bus_t EX_SB  = 8'h18;
    localparam alu_op_bus_t EX_SH  = 8'h19;
    localparam alu_op_bus_t EX_SW  = 8'h1A;

    // Memory-access FSM, 2-bit encoding
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load_op(input alu_op_bus_t op);
        return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
               (op == EX_LBU) || (op == EX_LHU);
    endfunction

    function automatic logic is_store_op(input alu_op_bus_t op);
        return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Combinational lane logic for the memory stage: load lane
//               select and extension, store lane replication, byte masks
//               and misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] op,
    input  logic [1:0]         off,
    input  logic [XLEN-1:0]    rdata,
    input  logic [XLEN-1:0]    sdata,
    output logic [XLEN-1:0]    load_data,
    output logic [XLEN-1:0]    store_data,
    output logic [3:0]         mask,
    output logic               misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane extraction from the raw word, then per-op extension, masks and alignment
    always_comb begin
        byte_lane  = rdata[{off, 3'b000} +: 8];
        half_lane  = rdata[{off[1], 4'b0000} +: 16];
        load_data  = '0;
        store_data = '0;
        mask       = 4'b0000;
        misalign   = 1'b0;
        case (op)
            EX_LB:  load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            EX_LBU: load_data = {{(XLEN-8){1'b0}}, byte_lane};
            EX_LH: begin
                misalign  = off[0];
                load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            end
            EX_LHU: begin
                misalign  = off[0];
                load_data = {{(XLEN-16){1'b0}}, half_lane};
            end
            EX_LW: begin
                misalign  = (off != 2'b00);
                load_data = rdata;
            end
            EX_SB: begin
                store_data = {(XLEN/8){sdata[7:0]}};
                mask       = 4'b0001 << off;
            end
            EX_SH: begin
                misalign   = off[0];
                store_data = {(XLEN/16){sdata[15:0]}};
                mask       = 4'b0011 << off;
            end
            EX_SW: begin
                misalign   = (off != 2'b00);
                store_data = sdata;
                mask       = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Issues word-wide load/store
//               requests over a req/ack handshake, stalls the pipeline while
//               an access is outstanding, and forwards results to MEM/WB.
//               Non-memory ops pass straight through combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [XLEN-1:0]    mem_addr_i,
    input  logic [XLEN-1:0]    w_data_i,
    input  logic               w_enable_i,
    input  logic [4:0]         w_addr_i,
    input  logic               is_ld_i,
    output logic               w_enable_o,
    output logic [4:0]         w_addr_o,
    output logic [XLEN-1:0]    w_data_o,
    output logic               stall_req_o,
    output logic               misalign_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    output logic [3:0]         mem_wmask_o,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic               mem_ack_i
);

    mem_state_t state_q, state_d;

    logic            req_we_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [3:0]      req_mask_q;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;
    logic [3:0]      store_mask;
    logic            align_err;

    logic is_load;
    logic is_store;
    logic is_mem;
    logic issue;
    logic dest_nz;

    // The EX/MEM latch is held while stalled, so lane offsets and op come
    // straight from the latch both at issue time and in DONE.
    mem_align #(
        .XLEN    (XLEN),
        .ALUOP_W (ALUOP_W)
    ) u_align (
        .op         (aluop_i),
        .off        (mem_addr_i[1:0]),
        .rdata      (rdata_q),
        .sdata      (w_data_i),
        .load_data  (load_data),
        .store_data (store_data),
        .mask       (store_mask),
        .misalign   (align_err)
    );

    assign is_load  = is_ld_i && is_load_op(aluop_i);
    assign is_store = is_store_op(aluop_i);
    assign is_mem   = is_load || is_store;
    assign issue    = (state_q == MEM_IDLE) && is_mem && !align_err;
    assign dest_nz  = (w_addr_i != 5'd0);

    // State register; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request registers loaded on issue and held until the next issue; read data captured on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_mask_q  <= 4'b0000;
            rdata_q     <= '0;
        end else begin
            if (issue) begin
                req_we_q    <= is_store;
                req_addr_q  <= {mem_addr_i[XLEN-1:2], 2'b00};
                req_wdata_q <= store_data;
                req_mask_q  <= store_mask;
            end
            if ((state_q == MEM_WAIT) && mem_ack_i) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Next-state and write-back / stall outputs; everything reads 0 while in reset
    always_comb begin
        state_d     = state_q;
        w_enable_o  = 1'b0;
        w_addr_o    = 5'd0;
        w_data_o    = ZERO_WORD;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (is_mem) begin
                    if (align_err) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                        state_d     = MEM_WAIT;
                    end
                end else begin
                    w_addr_o   = w_addr_i;
                    w_enable_o = w_enable_i && dest_nz;
                    w_data_o   = dest_nz ? w_data_i : ZERO_WORD;
                end
            end
            MEM_WAIT: begin
                stall_req_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                state_d  = MEM_IDLE;
                w_addr_o = w_addr_i;
                if (is_load) begin
                    w_enable_o = w_enable_i && dest_nz;
                    w_data_o   = dest_nz ? load_data : ZERO_WORD;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        if (!rst) begin
            w_enable_o  = 1'b0;
            w_addr_o    = 5'd0;
            w_data_o    = ZERO_WORD;
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
        end
    end

    assign mem_req_o   = (state_q == MEM_WAIT);
    assign mem_we_o    = req_we_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign mem_wmask_o = req_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] w_data_i;
    logic        w_enable_i;
    logic [4:0]  w_addr_i;
    logic        is_ld_i;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic        stall_req_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_mask;
    logic        cap_we;
    logic        cap_stable;
    int          stalls;
    int          reqs;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .ALUOP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .w_data_i    (w_data_i),
        .w_enable_i  (w_enable_i),
        .w_addr_i    (w_addr_i),
        .is_ld_i     (is_ld_i),
        .w_enable_o  (w_enable_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .stall_req_o (stall_req_o),
        .misalign_o  (misalign_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic we, input logic [4:0] wa, input logic ld);
        aluop_i    = op;
        mem_addr_i = addr;
        w_data_i   = data;
        w_enable_i = we;
        w_addr_i   = wa;
        is_ld_i    = ld;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called 2 ns after a clock edge with a memory op applied. Counts stall and
    // request cycles, acks on the ack_after-th request cycle, and returns in the
    // first non-stalled cycle (DONE) with inputs still held.
    task automatic run_mem(input int ack_after, input logic [31:0] rd);
        logic done;
        done       = 1'b0;
        stalls     = 0;
        reqs       = 0;
        cap_stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!stall_req_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req_o) begin
                reqs++;
                if (reqs == 1) begin
                    cap_addr  = mem_addr_o;
                    cap_wdata = mem_wdata_o;
                    cap_mask  = mem_wmask_o;
                    cap_we    = mem_we_o;
                end else if (cap_addr !== mem_addr_o || cap_wdata !== mem_wdata_o ||
                             cap_mask !== mem_wmask_o || cap_we !== mem_we_o) begin
                    cap_stable = 1'b0;
                end
                if (reqs == ack_after) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rd;
                end
            end
            @(posedge clk);
            #2;
            mem_ack_i = 1'b0;
        end
        check("mem_op_completes", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst         = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        set_op(EX_NOP, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall_req_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_wen", {31'd0, w_enable_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        rst = 1'b1;

        // ADD to x5: same-cycle pass-through
        set_op(EX_ADD, 32'd0, 32'h0000_1234, 1'b1, 5'd5, 1'b0);
        #1;
        check("add_wen", {31'd0, w_enable_o}, 32'd1);
        check("add_waddr", {27'd0, w_addr_o}, 32'd5);
        check("add_wdata", w_data_o, 32'h0000_1234);
        check("add_stall", {31'd0, stall_req_o}, 32'd0);
        check("add_req", {31'd0, mem_req_o}, 32'd0);

        // LB at 0x103 to x7, ack in first WAIT cycle
        next_cycle();
        set_op(EX_LB, 32'h0000_0103, 32'd0, 1'b1, 5'd7, 1'b1);
        #1;
        run_mem(1, 32'h80FF_0011);
        check("lb_stalls", stalls, 32'd2);
        check("lb_reqs", reqs, 32'd1);
        check("lb_memaddr", cap_addr, 32'h0000_0100);
        check("lb_we", {31'd0, cap_we}, 32'd0);
        check("lb_wen", {31'd0, w_enable_o}, 32'd1);
        check("lb_waddr", {27'd0, w_addr_o}, 32'd7);
        check("lb_wdata", w_data_o, 32'hFFFF_FF80);
        next_cycle();
        set_op(EX_NOP, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("lb_idle_stall", {31'd0, stall_req_o}, 32'd0);
        check("lb_idle_req", {31'd0, mem_req_o}, 32'd0);

        // SH at 0x202, ack after 3 WAIT cycles
        next_cycle();
        set_op(EX_SH, 32'h0000_0202, 32'hABCD_5678, 1'b0, 5'd0, 1'b0);
        #1;
        run_mem(3, 32'd0);
        check("sh_stalls", stalls, 32'd4);
        check("sh_reqs", reqs, 32'd3);
        check("sh_memaddr", cap_addr, 32'h0000_0200);
        check("sh_mask", {28'd0, cap_mask}, 32'h0000_000C);
        check("sh_wdata", cap_wdata, 32'h5678_5678);
        check("sh_we", {31'd0, cap_we}, 32'd1);
        check("sh_stable", {31'd0, cap_stable}, 32'd1);
        check("sh_wen", {31'd0, w_enable_o}, 32'd0);

        // SB at 0x101, ack after 2 WAIT cycles
        next_cycle();
        set_op(EX_SB, 32'h0000_0101, 32'h1234_56A5, 1'b0, 5'd0, 1'b0);
        #1;
        run_mem(2, 32'd0);
        check("sb_stalls", stalls, 32'd3);
        check("sb_mask", {28'd0, cap_mask}, 32'h0000_0002);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

        // LHU at 0x0FE to x9
        next_cycle();
        set_op(EX_LHU, 32'h0000_00FE, 32'd0, 1'b1, 5'd9, 1'b1);
        #1;
        run_mem(1, 32'hBEEF_0000);
        check("lhu_memaddr", cap_addr, 32'h0000_00FC);
        check("lhu_wdata", w_data_o, 32'h0000_BEEF);
        check("lhu_wen", {31'd0, w_enable_o}, 32'd1);

        // LW at 0x0FE: misaligned, no request, no stall
        next_cycle();
        set_op(EX_LW, 32'h0000_00FE, 32'd0, 1'b1, 5'd4, 1'b1);
        #1;
        check("lw_mis_flag", {31'd0, misalign_o}, 32'd1);
        check("lw_mis_stall", {31'd0, stall_req_o}, 32'd0);
        check("lw_mis_wen", {31'd0, w_enable_o}, 32'd0);
        next_cycle();
        check("lw_mis_req", {31'd0, mem_req_o}, 32'd0);

        // ADD to x0 is suppressed
        set_op(EX_ADD, 32'd0, 32'hCAFE_F00D, 1'b1, 5'd0, 1'b0);
        #1;
        check("x0_wen", {31'd0, w_enable_o}, 32'd0);
        check("x0_wdata", w_data_o, 32'd0);

        // Reset during WAIT of an LW, stray ack afterwards
        next_cycle();
        set_op(EX_LW, 32'h0000_0100, 32'd0, 1'b1, 5'd3, 1'b1);
        next_cycle();
        check("rw_req_wait", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b0;
        set_op(EX_NOP, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("rw_req_drop", {31'd0, mem_req_o}, 32'd0);
        check("rw_addr_clr", mem_addr_o, 32'd0);
        next_cycle();
        rst         = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("rw_req", {31'd0, mem_req_o}, 32'd0);
        check("rw_stall", {31'd0, stall_req_o}, 32'd0);
        check("rw_wen", {31'd0, w_enable_o}, 32'd0);
        check("rw_wdata", w_data_o, 32'd0);
        check("rw_we", {31'd0, mem_we_o}, 32'd0);
        check("rw_mask", {28'd0, mem_wmask_o}, 32'd0);
        check("rw_memwdata", mem_wdata_o, 32'd0);
        check("rw_misalign", {31'd0, misalign_o}, 32'd0);
        next_cycle();
        check("rw_req_later", {31'd0, mem_req_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
